// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/result widths, op encodings and the request
// record carried through the issue FIFO.
package alu_pkg;

    localparam int ALU_OPND_W = 4;
    localparam int ALU_RES_W  = 5;
    localparam int ALU_OP_W   = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_AND = 2'b10,
        ALU_OP_OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [ALU_OPND_W-1:0] a;
        logic [ALU_OPND_W-1:0] b;
        alu_op_e               op;
    } alu_req_t;

    localparam int ALU_REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu_issue_fifo.sv
// Generic synchronous FIFO with registered occupancy count; DEPTH must be a
// power of two so the pointers wrap naturally.
module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage for the combinational 4-bit ALU: in-order request FIFO, head
// drive to the ALU, tagged output register. ALU_ISSUE_PERF_EN adds perf counters.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_a,
    input  logic [3:0]            in_b,
    input  logic [1:0]            in_op,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [1:0]            alu_op,
    input  logic [4:0]            alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_result,
    output logic [TAG_W-1:0]      out_tag
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]           perf_issued,
    output logic [15:0]           perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens on a posedge where valid & ready are both
    // high; valid, once raised, holds its payload until that transfer.
    alu_req_t           wdata;
    alu_req_t           head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               issue;
    logic [TAG_W-1:0]   tag_cnt;

    assign wdata    = '{a: in_a, b: in_b, op: alu_op_e'(in_op)};
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign issue    = (fifo_count != '0) & (~out_valid | out_ready);

    alu_issue_fifo #(
        .WIDTH (ALU_REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (issue),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Idle ALU operands are forced to zero so the ALU never sees stale entries.
    assign alu_a  = fifo_empty ? '0 : head.a;
    assign alu_b  = fifo_empty ? '0 : head.b;
    assign alu_op = fifo_empty ? '0 : head.op;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            tag_cnt    <= '0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_tag    <= tag_cnt;
            tag_cnt    <= tag_cnt + TAG_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue && perf_issued != 16'hFFFF) perf_issued <= perf_issued + 16'd1;
            if (in_valid && !in_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue with a behavioural model of the ALU on the
// alu_* / alu_result loop.
module tb_alu_op_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [1:0]       in_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [1:0]       alu_op;
    logic [4:0]       alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]      perf_issued;
    logic [15:0]      perf_stall;
`endif

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    alu_op_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_req(input int n);
        in_valid = 1'b1;
        in_a     = 4'(n * 3);
        in_b     = 4'(n + 5);
        in_op    = 2'(n);
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (out_result !== 5'h00) begin bad++; $display("FAIL rst_out_result got=%0h want=0", out_result); end
        total++; if (out_tag !== 8'h00) begin bad++; $display("FAIL rst_out_tag got=%0h want=0", out_tag); end
        total++; if ({alu_a, alu_b, alu_op} !== 10'h000) begin bad++; $display("FAIL rst_alu got=%0h want=0", {alu_a, alu_b, alu_op}); end
`ifdef ALU_ISSUE_PERF_EN
        total++; if (perf_issued !== 16'd0 || perf_stall !== 16'd0) begin bad++; $display("FAIL rst_perf got=%0d/%0d want=0/0", perf_issued, perf_stall); end
`endif
    endtask

    task automatic test_single;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'h3; in_b = 4'h5; in_op = 2'b00;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", out_valid); end
        total++; if ({alu_a, alu_b, alu_op} !== {4'h3, 4'h5, 2'b00}) begin bad++; $display("FAIL single_head got=%0h want=%0h", {alu_a, alu_b, alu_op}, {4'h3, 4'h5, 2'b00}); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
        total++; if (out_result !== 5'h08) begin bad++; $display("FAIL single_result got=%0h want=08", out_result); end
        total++; if (out_tag !== 8'h00) begin bad++; $display("FAIL single_tag got=%0h want=0", out_tag); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%0b want=0", out_valid); end
    endtask

    task automatic test_mixed;
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [1:0] vop[4];
        logic [4:0] vr [4];
        va  = '{4'hF, 4'h3, 4'hA, 4'hC};
        vb  = '{4'h1, 4'h7, 4'h5, 4'h3};
        vop = '{2'b00, 2'b01, 2'b10, 2'b11};
        vr  = '{5'h10, 5'h1C, 5'h00, 5'h0F};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_op = vop[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mixed_valid[%0d] got=%0b want=1", i - 1, out_valid); end
                total++; if (out_result !== vr[i-1]) begin bad++; $display("FAIL mixed_result[%0d] got=%0h want=%0h", i - 1, out_result, vr[i-1]); end
                total++; if (out_tag !== 8'(i - 1)) begin bad++; $display("FAIL mixed_tag[%0d] got=%0h want=%0h", i - 1, out_tag, i - 1); end
            end
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int got;
        logic [4:0] want;
        do_reset();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) begin
                in_valid = 1'b1; in_a = idx[3:0]; in_b = 4'h1; in_op = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(alu_model(in_a, in_b, in_op));
                idx++;
            end
            step();
        end
        total++; if (idx !== 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", idx); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b want=0", in_ready); end
        total++; if (out_result !== 5'h01) begin bad++; $display("FAIL bp_hold got=%0h want=01", out_result); end
`ifdef ALU_ISSUE_PERF_EN
        total++; if (perf_stall !== 16'd3) begin bad++; $display("FAIL bp_perf_stall got=%0d want=3", perf_stall); end
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=%0h want=none", out_result);
                end else begin
                    want = exp_q.pop_front();
                    if (out_result !== want || out_tag !== 8'(got)) begin
                        bad++; $display("FAIL bp_drain[%0d] got=%0h/%0h want=%0h/%0h", got, out_result, out_tag, want, got);
                    end
                end
                got++;
            end
            step();
            if (c == 0) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b want=1", in_ready); end
            end
        end
        total++; if (got !== 5 || exp_q.size() != 0) begin bad++; $display("FAIL bp_drain_count got=%0d want=5", got); end
    endtask

    task automatic test_simul;
        int pushes;
        int got;
        logic [4:0] want;
        do_reset();
        pushes = 0;
        got    = 0;
        for (int c = 0; c < 3; c++) begin
            drive_req(pushes);
            if (in_valid && in_ready) begin exp_q.push_back(alu_model(in_a, in_b, in_op)); pushes++; end
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 10) drive_req(pushes);
            else in_valid = 1'b0;
            if (in_valid && in_ready) begin exp_q.push_back(alu_model(in_a, in_b, in_op)); pushes++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL simul_extra got=%0h want=none", out_result);
                end else begin
                    want = exp_q.pop_front();
                    if (out_result !== want || out_tag !== 8'(got)) begin
                        bad++; $display("FAIL simul_data[%0d] got=%0h/%0h want=%0h/%0h", got, out_result, out_tag, want, got);
                    end
                end
                got++;
            end
            step();
            if (c < 10) begin
                total++;
                if (pushes - got - int'(out_valid) != 2) begin
                    bad++; $display("FAIL simul_count[%0d] got=%0d want=2", c, pushes - got - int'(out_valid));
                end
            end
        end
        total++; if (got !== 13 || pushes !== 13) begin bad++; $display("FAIL simul_total got=%0d/%0d want=13/13", got, pushes); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_req(c);
            step();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%0b want=1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0b want=1", in_ready); end
        total++; if ({alu_a, alu_b, alu_op} !== 10'h000) begin bad++; $display("FAIL mrst_alu got=%0h want=0", {alu_a, alu_b, alu_op}); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'h2; in_b = 4'h2; in_op = 2'b00;
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_result !== 5'h04) begin bad++; $display("FAIL mrst_next got=%0b/%0h want=1/04", out_valid, out_result); end
        total++; if (out_tag !== 8'h00) begin bad++; $display("FAIL mrst_tag got=%0h want=0", out_tag); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale got=%0b want=0", out_valid); end
    endtask

    task automatic test_tag_wrap;
        int pushes;
        int got;
        int tag_errs;
        logic [4:0] want;
        do_reset();
        out_ready = 1'b1;
        pushes   = 0;
        got      = 0;
        tag_errs = 0;
        for (int c = 0; c < 300; c++) begin
            if (pushes < 257) drive_req(pushes);
            else in_valid = 1'b0;
            if (in_valid && in_ready) begin exp_q.push_back(alu_model(in_a, in_b, in_op)); pushes++; end
            if (out_valid && out_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h00;
                if (out_tag !== 8'(got) || out_result !== want) tag_errs++;
                if (got == 255 || got == 256) begin
                    total++;
                    if (out_tag !== 8'(got)) begin bad++; $display("FAIL wrap_tag[%0d] got=%0h want=%0h", got, out_tag, 8'(got)); end
                end
                got++;
            end
            step();
        end
        total++; if (tag_errs != 0) begin bad++; $display("FAIL wrap_stream got=%0d errors want=0", tag_errs); end
        total++; if (got !== 257) begin bad++; $display("FAIL wrap_count got=%0d want=257", got); end
`ifdef ALU_ISSUE_PERF_EN
        total++; if (perf_issued !== 16'd257) begin bad++; $display("FAIL wrap_perf_issued got=%0d want=257", perf_issued); end
        total++; if (perf_stall !== 16'd0) begin bad++; $display("FAIL wrap_perf_stall got=%0d want=0", perf_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_backpressure();
        test_simul();
        test_mid_reset();
        test_tag_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
